prioq_sched: RTL and testbench
==============================

Name: prioq_sched

Overview:
- Scheduler that shares one 4-bit priority queue (`prioq`: in[3:0] = {prio[1:0], id[1:0]}, ende 0 = enqueue / 1 = dequeue) between 4 producers and 1 consumer.
- Arbitrates producer enqueue requests round-robin and serialises them against consumer dequeue requests.
- Tracks queue occupancy, issues one-cycle command strobes to the queue, and captures dequeued entries with a valid pulse.
- Sits directly in front of the queue instance; the queue never sees an enqueue when full or a dequeue when empty.

Parameters:
- DEPTH, 4: queue capacity in entries.
- CNT_W, 3: occupancy counter width; must satisfy 2^CNT_W > DEPTH.
- Q_LAT, 1: cycles from the dequeue command edge to valid q_out (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-producer enqueue request; held until the matching gnt bit.
- req_prio  in  8  producer i priority on bits [2i+1:2i].
- gnt  out  4  one-hot, one-cycle grant; coincides with the queue command.
- deq_req  in  1  consumer dequeue request; level.
- deq_valid  out  1  one-cycle pulse; deq_data valid.
- deq_data  out  4  dequeued {prio, id}.
- q_en  out  1  queue command strobe.
- q_ende  out  1  queue op: 0 = enqueue, 1 = dequeue.
- q_in  out  4  queue entry {prio, id}; id = granted producer index.
- q_out  in  4  queue output.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, rst_n = 0) sets these values:
  - state = IDLE, gnt = 0, q_en = 0, q_ende = 0, q_in = 0.
  - deq_valid = 0, deq_data = 0, count = 0, rr_ptr = 0.
  - empty = 1, full = 0.
  - Reset mid-operation aborts any command or wait; an in-flight dequeue result is discarded.
- FSM states: IDLE, ENQ, DEQ, WAIT. All outputs are registered.
- IDLE decision, made at each edge:
  - If deq_req && !empty: go to DEQ. Dequeue has priority over enqueue.
  - Else if |req && !full: go to ENQ. Winner = first set req bit searching from rr_ptr upward, mod 4.
  - Else stay in IDLE.
  - While full, req is ignored and not granted. While empty, deq_req is ignored.
- ENQ (1 cycle):
  - Outputs: q_en = 1, q_ende = 0, q_in = {req_prio[winner], winner}, gnt[winner] = 1.
  - At the exit edge: count += 1, rr_ptr = winner + 1 (mod 4), next state IDLE.
  - Throughput: 1 enqueue per 2 cycles.
- DEQ (1 cycle):
  - Outputs: q_en = 1, q_ende = 1, gnt = 0.
  - At the exit edge: count -= 1, next state WAIT.
- WAIT (Q_LAT cycles, internal down-counter):
  - q_en = 0.
  - At the final edge: deq_data <= q_out, deq_valid = 1 for the next cycle, next state IDLE.
  - deq_req is not re-sampled until IDLE.
- q_en is 0 in IDLE and WAIT. q_in and q_ende hold their last values when q_en = 0.
- count never wraps: no increment at DEPTH, no decrement at 0. This is guaranteed by the IDLE guards.
- full and empty are decoded combinationally from the count register.
- A req held continuously by a producer is re-granted on a later IDLE visit (multiple entries allowed).
- A req dropped before grant withdraws the request; no grant is issued.

Optional Feature:
- Macro: PRIOQ_SCHED_STATS_EN.
- When defined:
  - Adds outputs enq_total[7:0] and deq_total[7:0].
  - Incremented on ENQ and DEQ exit respectively; saturate at 255.
  - Adds output rej_full[7:0]: counts IDLE cycles with |req && full, saturating at 255.
  - All three clear on rst_n.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_n = 0 mid-WAIT, after a dequeue command -> all outputs at reset values immediately; no deq_valid pulse after release.
- Single enqueue: req = 4'b0010, req_prio = 8'b0000_1100 -> one cycle later q_en = 1, q_ende = 0, q_in = 4'b1101, gnt = 4'b0010; then count = 1, empty = 0.
- Round-robin: req = 4'b1111 held -> grants in order 0001, 0010, 0100, 1000 on cycles 1, 3, 5, 7; count reaches 4, full = 1; no 5th grant while req is held.
- Dequeue latency (Q_LAT = 1, queue model returns 4'b1110): deq_req = 1 with count = 2 -> DEQ strobe (q_ende = 1), then deq_valid pulse with deq_data = 4'b1110 two edges after the DEQ edge; count = 1.
- Simultaneous events: deq_req = 1 and req = 4'b0001 with count = 1 -> DEQ first, then ENQ grant on the next IDLE visit; count goes 1 -> 0 -> 1.
- Empty guard: deq_req = 1 with count = 0 -> q_en stays 0 and no deq_valid. With PRIOQ_SCHED_STATS_EN: 10 IDLE cycles with req while full -> rej_full = 10.

Source files
------------

// File: rtl/prioq_sched.sv
// rtl/prioq_sched.sv - round-robin enqueue / dequeue scheduler in front of a 4-entry priority queue
// Optional occupancy statistics (enq_total, deq_total, rej_full) under macro PRIOQ_SCHED_STATS_EN.
module prioq_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3,
    parameter int Q_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [7:0]       req_prio,
    output logic [3:0]       gnt,
    input  logic             deq_req,
    output logic             deq_valid,
    output logic [3:0]       deq_data,
    output logic             q_en,
    output logic             q_ende,
    output logic [3:0]       q_in,
    input  logic [3:0]       q_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
`ifdef PRIOQ_SCHED_STATS_EN
    ,
    output logic [7:0]       enq_total,
    output logic [7:0]       deq_total,
    output logic [7:0]       rej_full
`endif
);

    typedef enum logic [1:0] {IDLE, ENQ, DEQ, WAIT} state_t;

    localparam logic [1:0] WAIT_INIT = 2'(Q_LAT - 1);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] wcnt;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // First requesting producer at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        winner = rr_ptr;
        idx    = rr_ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            q_en      <= 1'b0;
            q_ende    <= 1'b0;
            q_in      <= '0;
            deq_valid <= 1'b0;
            deq_data  <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            wcnt      <= '0;
`ifdef PRIOQ_SCHED_STATS_EN
            enq_total <= '0;
            deq_total <= '0;
            rej_full  <= '0;
`endif
        end else begin
            gnt       <= '0;
            q_en      <= 1'b0;
            deq_valid <= 1'b0;
            case (state)
                IDLE: begin
`ifdef PRIOQ_SCHED_STATS_EN
                    if (|req && full && rej_full != 8'hFF)
                        rej_full <= rej_full + 8'd1;
`endif
                    if (deq_req && !empty) begin
                        state  <= DEQ;
                        q_en   <= 1'b1;
                        q_ende <= 1'b1;
                    end else if (|req && !full) begin
                        state  <= ENQ;
                        q_en   <= 1'b1;
                        q_ende <= 1'b0;
                        q_in   <= {req_prio[{winner, 1'b0} +: 2], winner};
                        gnt    <= 4'b0001 << winner;
                    end
                end
                ENQ: begin
                    // q_in[1:0] still holds the granted producer index.
                    count  <= count + CNT_W'(1);
                    rr_ptr <= q_in[1:0] + 2'd1;
                    state  <= IDLE;
`ifdef PRIOQ_SCHED_STATS_EN
                    if (enq_total != 8'hFF)
                        enq_total <= enq_total + 8'd1;
`endif
                end
                DEQ: begin
                    count <= count - CNT_W'(1);
                    wcnt  <= WAIT_INIT;
                    state <= WAIT;
`ifdef PRIOQ_SCHED_STATS_EN
                    if (deq_total != 8'hFF)
                        deq_total <= deq_total + 8'd1;
`endif
                end
                WAIT: begin
                    if (wcnt == 2'd0) begin
                        deq_data  <= q_out;
                        deq_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wcnt <= wcnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prioq_sched.sv
// tb/tb_prioq_sched.sv - scoreboard bench for prioq_sched with a behavioural priority queue
module tb_prioq_sched;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int Q_LAT = 1;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [7:0]       req_prio;
    logic [3:0]       gnt;
    logic             deq_req;
    logic             deq_valid;
    logic [3:0]       deq_data;
    logic             q_en;
    logic             q_ende;
    logic [3:0]       q_in;
    logic [3:0]       q_out;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef PRIOQ_SCHED_STATS_EN
    logic [7:0]       enq_total;
    logic [7:0]       deq_total;
    logic [7:0]       rej_full;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    prioq_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W), .Q_LAT(Q_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_prio(req_prio), .gnt(gnt),
        .deq_req(deq_req), .deq_valid(deq_valid), .deq_data(deq_data),
        .q_en(q_en), .q_ende(q_ende), .q_in(q_in), .q_out(q_out),
        .count(count), .full(full), .empty(empty)
`ifdef PRIOQ_SCHED_STATS_EN
        , .enq_total(enq_total), .deq_total(deq_total), .rej_full(rej_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Queue policy: highest prio wins, oldest first among equals.
    function automatic int pick(input logic [3:0] arr[$]);
        int b = 0;
        for (int i = 1; i < arr.size(); i++)
            if (arr[i][3:2] > arr[b][3:2]) b = i;
        return b;
    endfunction

    // Stand-in for the queue instance driven by the scheduler.
    logic [3:0] stub_q[$];
    int         sb_idx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_q.delete();
            q_out <= 4'h0;
        end else if (q_en) begin
            checks++;
            if (!q_ende) begin
                if (stub_q.size() >= DEPTH) begin
                    errors++;
                    $display("FAIL queue_overflow: got enqueue with %0d entries required < %0d", stub_q.size(), DEPTH);
                end
                stub_q.push_back(q_in);
            end else if (stub_q.size() == 0) begin
                errors++;
                $display("FAIL queue_underflow: got dequeue with 0 entries required > 0");
            end else begin
                sb_idx = pick(stub_q);
                q_out <= stub_q[sb_idx];
                stub_q.delete(sb_idx);
            end
        end
    end

    // Reference model: transaction-level view of the scheduler.
    typedef struct {
        int         kind;   // 0 enqueue grant, 1 dequeue command, 2 dequeue result
        int         at;
        logic [3:0] g;
        logic [3:0] val;
    } ev_t;

    ev_t        sb[$];
    ev_t        em;
    ev_t        ec;
    logic [3:0] ref_q[$];
    int         m_cnt, m_busy, m_rr, m_pend, m_vis, m_enq, m_deq, b, w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_cnt = 0; m_busy = 0; m_rr = 0; m_pend = 0; m_vis = 0;
            m_enq = 0; m_deq = 0;
            ref_q.delete();
            sb.delete();
        end else begin
            cyc++;
            m_vis += m_pend;
            m_pend = 0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (deq_req && m_cnt > 0) begin
                b = pick(ref_q);
                em.kind = 1; em.at = cyc; em.g = 4'h0; em.val = 4'h0;
                sb.push_back(em);
                em.kind = 2; em.at = cyc + 1 + Q_LAT; em.val = ref_q[b];
                sb.push_back(em);
                ref_q.delete(b);
                m_cnt--; m_pend = -1; m_busy = 1 + Q_LAT; m_deq++;
            end else if (req != 4'h0 && m_cnt < DEPTH) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
                em.kind = 0; em.at = cyc; em.g = 4'(1 << w);
                em.val = {req_prio[2*w +: 2], 2'(w)};
                sb.push_back(em);
                ref_q.push_back(em.val);
                m_cnt++; m_pend = 1; m_rr = (w + 1) % 4; m_busy = 1; m_enq++;
            end
        end
    end

    // Monitor: occupancy every cycle, scoreboard pop on any DUT strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (count != m_vis || full != (m_vis == DEPTH) || empty != (m_vis == 0)) begin
                errors++;
                $display("FAIL occupancy: got count=%0d full=%0b empty=%0b required count=%0d", count, full, empty, m_vis);
            end
            while (sb.size() > 0 && sb[0].at < cyc) begin
                ec = sb.pop_front();
                checks++; errors++;
                $display("FAIL missing_event: got nothing required kind=%0d at cycle %0d", ec.kind, ec.at);
            end
            if (q_en || gnt != 4'h0 || deq_valid) begin
                checks++;
                if (sb.size() == 0 || sb[0].at != cyc) begin
                    errors++;
                    $display("FAIL unexpected_event: got q_en=%0b gnt=%0h deq_valid=%0b required idle at cycle %0d", q_en, gnt, deq_valid, cyc);
                end else begin
                    ec = sb.pop_front();
                    if (ec.kind == 0 && !(q_en && !q_ende && gnt == ec.g && q_in == ec.val && !deq_valid)) begin
                        errors++;
                        $display("FAIL enq_cmd: got q_en=%0b q_ende=%0b gnt=%0h q_in=%0h required gnt=%0h q_in=%0h", q_en, q_ende, gnt, q_in, ec.g, ec.val);
                    end else if (ec.kind == 1 && !(q_en && q_ende && gnt == 4'h0 && !deq_valid)) begin
                        errors++;
                        $display("FAIL deq_cmd: got q_en=%0b q_ende=%0b gnt=%0h required q_en=1 q_ende=1 gnt=0", q_en, q_ende, gnt);
                    end else if (ec.kind == 2 && !(deq_valid && deq_data == ec.val && !q_en && gnt == 4'h0)) begin
                        errors++;
                        $display("FAIL deq_result: got deq_valid=%0b deq_data=%0h required deq_data=%0h", deq_valid, deq_data, ec.val);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        req = 4'h0; req_prio = 8'h00; deq_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt", gnt, 0);
        chk("rst_q_en", q_en, 0);
        chk("rst_q_ende", q_ende, 0);
        chk("rst_q_in", q_in, 0);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_deq_data", deq_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
`ifdef PRIOQ_SCHED_STATS_EN
        chk("rst_enq_total", enq_total, 0);
        chk("rst_deq_total", deq_total, 0);
        chk("rst_rej_full", rej_full, 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        do_reset();
        chk_reset_outputs();

        // Empty guard: dequeue requests with nothing queued.
        deq_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("empty_guard_q_en", q_en, 0);
            chk("empty_guard_valid", deq_valid, 0);
        end
        deq_req = 1'b0;

        // Single enqueue from producer 1 at prio 3.
        do_reset();
        req = 4'b0010; req_prio = 8'b0000_1100;
        @(negedge clk);
        chk("single_q_en", q_en, 1);
        chk("single_q_ende", q_ende, 0);
        chk("single_q_in", q_in, 4'b1101);
        chk("single_gnt", gnt, 4'b0010);
        req = 4'b0000;
        @(negedge clk);
        chk("single_count", count, 1);
        chk("single_empty", empty, 0);

        // Round-robin with all producers holding req until full.
        do_reset();
        req = 4'b1111; req_prio = 8'b11_10_01_00;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("rr_gnt", gnt, (c == 1) ? 1 : (c == 3) ? 2 : (c == 5) ? 4 : (c == 7) ? 8 : 0);
        end
        chk("rr_count", count, 4);
        chk("rr_full", full, 1);
`ifdef PRIOQ_SCHED_STATS_EN
        chk("rej_full_start", rej_full, 2);
        repeat (10) @(negedge clk);
        chk("rej_full_10", rej_full, 12);
`endif

        // Dequeue latency with two queued entries.
        do_reset();
        req = 4'b0101; req_prio = 8'b00_11_00_01;
        repeat (3) @(negedge clk);
        req = 4'b0000; deq_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("deq_cmd_q_en", q_en, 1);
        chk("deq_cmd_q_ende", q_ende, 1);
        deq_req = 1'b0;
        @(negedge clk);
        chk("deq_wait_valid", deq_valid, 0);
        chk("deq_count", count, 1);
        @(negedge clk);
        chk("deq_valid", deq_valid, 1);
        chk("deq_data", deq_data, 4'b1110);

        // Simultaneous dequeue and enqueue with one entry: dequeue first.
        deq_req = 1'b1; req = 4'b0001; req_prio = 8'b0000_0010;
        @(negedge clk);
        chk("sim_deq_first", q_ende, 1);
        chk("sim_no_gnt", gnt, 0);
        @(negedge clk);
        chk("sim_count0", count, 0);
        repeat (2) @(negedge clk);
        chk("sim_gnt", gnt, 4'b0001);
        req = 4'b0000; deq_req = 1'b0;
        @(negedge clk);
        chk("sim_count1", count, 1);

        // Reset in the middle of WAIT.
        deq_req = 1'b1;
        @(negedge clk);
        chk("rw_deq_cmd", q_en && q_ende, 1);
        deq_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rw_no_valid", deq_valid, 0);
        end

        // Randomised traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            req      = 4'($urandom);
            if ($urandom_range(0, 2) == 0) req = 4'h0;
            req_prio = 8'($urandom);
            deq_req  = ($urandom_range(0, 9) < 4);
            @(negedge clk);
        end
        req = 4'h0; deq_req = 1'b0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
`ifdef PRIOQ_SCHED_STATS_EN
        chk("enq_total", enq_total, (m_enq > 255) ? 255 : m_enq);
        chk("deq_total", deq_total, (m_deq > 255) ? 255 : m_deq);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
